stream_accumulator: RTL and testbench
=====================================

# stream_accumulator

Parametrised, sequential successor to the combinational signed adder. It accumulates a framed stream of signed WIDTH-bit operands into a signed ACC_WIDTH-bit sum, one operand per cycle, and handles overflow in one of two selectable modes: saturating or wrap-around. It sits in the neuron datapath between the weighted-input stage and the activation stage, and presents one sum per frame on a valid/ready output.

## Interface
- Parameters:
  - WIDTH, 8: operand width, signed two's complement.
  - ACC_WIDTH, 16: accumulator and result width, signed. Must be ≥ WIDTH.
  - CNT_WIDTH, 8: width of the operand counter.
  - SATURATE, 1: 1 = clamp on overflow, 0 = wrap modulo 2^ACC_WIDTH.
- Ports:
  - clk  in  1  single clock; all logic on the rising edge.
  - rst  in  1  reset, synchronous, active-high.
  - in_valid  in  1  operand beat valid.
  - in_ready  out  1  block can accept an operand.
  - in_data  in  WIDTH  signed operand.
  - in_last  in  1  marks the final operand of a frame.
  - out_valid  out  1  frame result valid.
  - out_ready  in  1  downstream accepts the result.
  - out_sum  out  ACC_WIDTH  signed frame sum.
  - out_overflow  out  1  at least one overflow occurred in the frame.
  - out_count  out  CNT_WIDTH  number of operands accepted in the frame.

## Operation
- Two-state FSM: ACCUM and HOLD.
- **Accept rule:** a beat is accepted on a rising edge where in_valid && in_ready. No other condition accepts a beat.
- **ACCUM state:**
  - in_ready = 1 and out_valid = 0.
  - On each accepted beat, acc <= f(acc + sext(in_data)).
  - The sum is computed in ACC_WIDTH+1 bits. Overflow means the top two bits of that sum differ.
  - On overflow with SATURATE=1, acc becomes 2^(ACC_WIDTH-1)-1 for a positive overflow, or -2^(ACC_WIDTH-1) for a negative one.
  - On overflow with SATURATE=0, acc takes the low ACC_WIDTH bits.
  - ovf flag is sticky: set on any overflow in the frame.
  - Accumulation continues from the clamped or wrapped value; there is no lock-out.
  - cnt increments by 1 per accepted beat and saturates at all-ones.
- **ACCUM to HOLD:** on an accepted beat with in_last = 1:
  - out_sum, out_overflow and out_count are loaded with the values including that beat.
  - State moves to HOLD.
- **HOLD state:**
  - in_ready = 0 and out_valid = 1.
  - out_sum, out_overflow and out_count are stable until the handshake.
  - in_valid is ignored; in_data is not consumed.
- **HOLD to ACCUM:** on out_valid && out_ready:
  - acc, cnt and ovf are cleared to 0.
  - State returns to ACCUM.
  - out_* data registers keep their last value; only out_valid drops.
- **Reset:** rst asserted in any state, including mid-frame, discards the partial sum.
  - State ACCUM; acc, cnt and ovf = 0.
- **Reset values of outputs:** in_ready = 1, out_valid = 0, out_sum = 0, out_overflow = 0, out_count = 0.
- in_valid is ignored on cycles where rst = 1.
- **Single-beat frame:** in_last on the first beat is legal. Result = sext(in_data), count = 1.
- **Empty frames** do not exist: a frame always contains the in_last beat.

## Timing
- Throughput in ACCUM: one operand per cycle.
- Latency: last beat accepted at edge N → out_valid = 1 from edge N (visible in cycle N+1).
- Result handshake at edge M → in_ready = 1 from edge M. The next frame's first beat can be accepted at edge M+1.
- Minimum gap between frames is therefore one cycle (the HOLD cycle), even when out_ready is held at 1.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from inputs to outputs.
- Backpressure: out_ready may stay low indefinitely. The block holds HOLD and keeps in_ready = 0.

## Test plan
All cases use WIDTH=8 unless noted.
- **Basic frame** (ACC_WIDTH=16): after reset, send {5, 10, -3} with in_last on -3 → out_sum = 12, out_count = 3, out_overflow = 0. out_valid rises the cycle after the last beat.
- **Saturation** (ACC_WIDTH=8, SATURATE=1):
  - {127, 1} → out_sum = 127, out_overflow = 1.
  - {-128, -1} → -128, ovf = 1.
  - {127, 1, -1} → 126, ovf = 1.
- **Wrap** (ACC_WIDTH=8, SATURATE=0): {127, 1} → out_sum = -128, ovf = 1. {100, 100, -100} → 100, ovf = 1.
- **Backpressure:** hold out_ready = 0 for 5 cycles after a result while in_valid = 1 with data 9.
  - Required during hold: in_ready = 0 and out_* stable.
  - Then out_ready = 1 → in_ready = 1 next cycle.
  - Frame {9} → out_sum = 9, out_count = 1, showing the accumulator was cleared.
- **Reset mid-frame:** accept {50, 50} without in_last, assert rst for 1 cycle, then send frame {-7} with in_last → out_sum = -7, out_count = 1, out_overflow = 0.
- **Counter and random frames:**
  - 300-beat frame of +1 (ACC_WIDTH=16, CNT_WIDTH=8) → out_sum = 300, out_count = 255 (saturated).
  - 20 random frames of random length with random in_valid/out_ready, checked against an ACC_WIDTH+1-bit reference model.

Source files
------------

// File: rtl/stream_accumulator.sv
// Framed signed accumulator: sums one operand per cycle and presents one result
// per frame on a valid/ready output. Overflow either clamps or wraps.
module stream_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 8,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_overflow,
  output logic [CNT_WIDTH-1:0] out_count
);

  localparam int SW = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {ACCUM, HOLD} state_t;

  typedef struct packed {
    logic [ACC_WIDTH-1:0] sum;
    logic                 ovf;
    logic [CNT_WIDTH-1:0] cnt;
  } frame_t;

  state_t  state_q, state_d;
  frame_t  acc_q, acc_d, res_q;
  logic [SW-1:0] sum_ext;
  logic          ovf_now;

  // One extra bit of headroom: top two bits disagree only on overflow.
  always_comb begin
    sum_ext = {acc_q.sum[ACC_WIDTH-1], acc_q.sum}
            + {{(SW-WIDTH){in_data[WIDTH-1]}}, in_data};
    ovf_now = sum_ext[SW-1] ^ sum_ext[SW-2];
    acc_d     = acc_q;
    acc_d.sum = sum_ext[ACC_WIDTH-1:0];
    if (ovf_now && SATURATE)
      acc_d.sum = sum_ext[SW-1] ? SMIN : SMAX;
    acc_d.ovf = acc_q.ovf | ovf_now;
    acc_d.cnt = (&acc_q.cnt) ? acc_q.cnt : acc_q.cnt + CNT_WIDTH'(1);
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // Result registers keep the last frame after the handshake; only out_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      res_q <= '0;
    end else if (in_valid && in_ready) begin
      acc_q <= acc_d;
      if (in_last) res_q <= acc_d;
    end else if (out_valid && out_ready) begin
      acc_q <= '0;
    end
  end

  assign out_sum      = res_q.sum;
  assign out_overflow = res_q.ovf;
  assign out_count    = res_q.cnt;

endmodule

// File: tb/tb_stream_accumulator.sv
// Drives three accumulator configurations with one shared stream and checks
// every cycle against an integer-arithmetic reference model.
module tb_stream_accumulator;

  logic clk = 1'b0;
  logic rst, in_valid, in_last, out_ready;
  logic [7:0] in_data;

  // 0: ACC16 saturating, 1: ACC8 saturating, 2: ACC8 wrapping
  logic [2:0] rdy, vld, ovf;
  logic [15:0] sum16;
  logic [7:0]  sum8s, sum8w;
  logic [7:0]  cnt0, cnt1, cnt2;

  always #5 clk = ~clk;

  stream_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8), .SATURATE(1'b1)) u_a16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
    .in_last(in_last), .out_valid(vld[0]), .out_ready(out_ready), .out_sum(sum16),
    .out_overflow(ovf[0]), .out_count(cnt0));
  stream_accumulator #(.WIDTH(8), .ACC_WIDTH(8), .CNT_WIDTH(8), .SATURATE(1'b1)) u_a8s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
    .in_last(in_last), .out_valid(vld[1]), .out_ready(out_ready), .out_sum(sum8s),
    .out_overflow(ovf[1]), .out_count(cnt1));
  stream_accumulator #(.WIDTH(8), .ACC_WIDTH(8), .CNT_WIDTH(8), .SATURATE(1'b0)) u_a8w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
    .in_last(in_last), .out_valid(vld[2]), .out_ready(out_ready), .out_sum(sum8w),
    .out_overflow(ovf[2]), .out_count(cnt2));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: plain integers, one frame result per configuration.
  int accw [3] = '{16, 8, 8};
  bit satm [3] = '{1'b1, 1'b1, 1'b0};
  int m_acc [3];
  bit m_ovf [3];
  int m_rsum [3];
  bit m_rovf [3];
  int m_cnt, m_rcnt;
  bit m_hold;

  function automatic int wrap(input int v, input int w);
    int m, r;
    m = 1 << w;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic int dut_sum(input int k);
    case (k)
      0:       return int'($signed(sum16));
      1:       return int'($signed(sum8s));
      default: return int'($signed(sum8w));
    endcase
  endfunction

  function automatic int dut_cnt(input int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit v, input int d, input bit l, input bit o);
    int s, hi, lo;
    if (r) begin
      m_hold = 0; m_cnt = 0; m_rcnt = 0;
      for (int k = 0; k < 3; k++) begin
        m_acc[k] = 0; m_ovf[k] = 0; m_rsum[k] = 0; m_rovf[k] = 0;
      end
    end else if (!m_hold) begin
      if (v) begin
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        for (int k = 0; k < 3; k++) begin
          hi = (1 << (accw[k] - 1)) - 1;
          lo = -(1 << (accw[k] - 1));
          s  = m_acc[k] + d;
          if (s > hi || s < lo) begin
            m_ovf[k] = 1;
            if (satm[k]) s = (s > hi) ? hi : lo;
            else         s = wrap(s, accw[k]);
          end
          m_acc[k] = s;
        end
        if (l) begin
          m_hold = 1;
          m_rcnt = m_cnt;
          for (int k = 0; k < 3; k++) begin
            m_rsum[k] = m_acc[k]; m_rovf[k] = m_ovf[k];
          end
        end
      end
    end else if (o) begin
      m_hold = 0; m_cnt = 0;
      for (int k = 0; k < 3; k++) begin
        m_acc[k] = 0; m_ovf[k] = 0;
      end
    end
  endtask

  // Inputs are stable when step is called; model advances on the edge,
  // DUT outputs are compared 1ns later.
  task automatic step();
    bit r, v, l, o;
    int d;
    r = rst; v = in_valid; l = in_last; o = out_ready; d = int'($signed(in_data));
    @(posedge clk);
    model_edge(r, v, d, l, o);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("in_ready[%0d]", k), int'(rdy[k]), int'(!m_hold));
      chk($sformatf("out_valid[%0d]", k), int'(vld[k]), int'(m_hold));
      chk($sformatf("out_sum[%0d]", k), dut_sum(k), m_rsum[k]);
      chk($sformatf("out_overflow[%0d]", k), int'(ovf[k]), int'(m_rovf[k]));
      chk($sformatf("out_count[%0d]", k), dut_cnt(k), m_rcnt);
    end
  endtask

  task automatic wait_accum();
    for (int i = 0; i < 200 && m_hold; i++) begin
      out_ready = 1'($urandom_range(1));
      in_valid  = 1'($urandom_range(1));
      in_last   = 1'($urandom_range(1));
      in_data   = 8'($urandom);
      step();
    end
    if (m_hold) chk("wait_accum_timeout", 1, 0);
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic send_frame(input int q[$], input bit rnd);
    wait_accum();
    foreach (q[i]) begin
      if (rnd) begin
        while ($urandom_range(3) == 0) begin
          in_valid = 1'b0; out_ready = 1'($urandom_range(1)); step();
        end
        out_ready = 1'($urandom_range(1));
      end
      in_valid = 1'b1;
      in_data  = 8'(q[i]);
      in_last  = (i == q.size() - 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int q[$];
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // Basic frame
    q = {5, 10, -3};
    send_frame(q, 0);
    chk("basic_valid", int'(vld[0]), 1);
    chk("basic_sum", dut_sum(0), 12);
    chk("basic_cnt", dut_cnt(0), 3);
    chk("basic_ovf", int'(ovf[0]), 0);

    // Backpressure with a pending beat of 9 held on the input
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'd9; in_last = 1'b1;
    repeat (5) begin
      step();
      chk("bp_in_ready", int'(rdy[0]), 0);
      chk("bp_sum_stable", dut_sum(0), 12);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_ready", int'(rdy[0]), 1);
    out_ready = 1'b0;
    step();
    chk("bp_frame_sum", dut_sum(0), 9);
    chk("bp_frame_cnt", dut_cnt(0), 1);
    in_valid = 1'b0; in_last = 1'b0;
    release_result();

    q = {127, 1};
    send_frame(q, 0);
    chk("sat_pos_sum", dut_sum(1), 127);
    chk("sat_pos_ovf", int'(ovf[1]), 1);
    chk("wrap_pos_sum", dut_sum(2), -128);
    chk("wrap_pos_ovf", int'(ovf[2]), 1);
    chk("wide_no_ovf_sum", dut_sum(0), 128);
    release_result();

    q = {-128, -1};
    send_frame(q, 0);
    chk("sat_neg_sum", dut_sum(1), -128);
    chk("sat_neg_ovf", int'(ovf[1]), 1);
    release_result();

    q = {127, 1, -1};
    send_frame(q, 0);
    chk("sat_continue_sum", dut_sum(1), 126);
    chk("sat_continue_ovf", int'(ovf[1]), 1);
    release_result();

    q = {100, 100, -100};
    send_frame(q, 0);
    chk("wrap_back_sum", dut_sum(2), 100);
    chk("wrap_back_ovf", int'(ovf[2]), 1);
    chk("sat_clip_sum", dut_sum(1), 27);
    release_result();

    // Reset mid-frame discards the partial sum
    in_valid = 1'b1; in_data = 8'd50; in_last = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_sum_cleared", dut_sum(0), 0);
    q = {-7};
    send_frame(q, 0);
    chk("rst_frame_sum", dut_sum(0), -7);
    chk("rst_frame_cnt", dut_cnt(0), 1);
    chk("rst_frame_ovf", int'(ovf[0]), 0);
    release_result();

    // Counter saturation
    q = {};
    repeat (300) q.push_back(1);
    send_frame(q, 0);
    chk("long_sum", dut_sum(0), 300);
    chk("long_cnt", dut_cnt(0), 255);
    chk("long_wrap_sum", dut_sum(2), 44);
    release_result();

    // Random frames with random gaps and backpressure
    for (int f = 0; f < 20; f++) begin
      q = {};
      repeat ($urandom_range(1, 40)) q.push_back(int'($urandom_range(255)) - 128);
      send_frame(q, 1);
    end
    wait_accum();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
